// File: rtl/npc_wbu.sv
// Write-back unit: accepts one retiring instruction, waits for load data, extends it and
// issues a single-cycle register-file write. Optional forwarding: define NPC_WBU_FWD_EN.
module npc_wbu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  input  logic        in_is_load,
  input  logic [2:0]  in_ld_func,
  input  logic [1:0]  in_ld_addr_lo,
  input  logic [31:0] in_result,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        retire,
`ifdef NPC_WBU_FWD_EN
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
`endif
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        hazard
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitMem = 2'd1,
    StWrite   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  rd_q;
  logic        rd_wen_q;
  logic [2:0]  ld_func_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] data_q;

  logic        accept;
  logic        mem_take;
  logic        pending;
  logic        src_match;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_q      <= 5'd0;
      rd_wen_q  <= 1'b0;
      ld_func_q <= 3'd0;
      addr_lo_q <= 2'd0;
      data_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q      <= in_rd;
        rd_wen_q  <= in_rd_wen;
        ld_func_q <= in_ld_func;
        addr_lo_q <= in_ld_addr_lo;
        data_q    <= in_result;
      end else if (mem_take) begin
        data_q <= ld_ext;
      end
    end
  end

  // Little-endian lane select and extension of the raw memory word.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_lo_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_func_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = in_is_load ? StWaitMem : StWrite;
      StWaitMem: if (mem_take) state_d = StWrite;
      StWrite:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // All outputs are gated by rst so they read zero for the whole reset cycle.
  always_comb begin
    in_ready   = (state_q == StIdle) && !rst;
    mem_rready = (state_q == StWaitMem) && !rst;
    accept     = in_valid && in_ready;
    mem_take   = mem_rvalid && mem_rready;
    pending    = (state_q != StIdle) && rd_wen_q && (rd_q != 5'd0) && !rst;
    src_match  = (chk_rs1 == rd_q) || (chk_rs2 == rd_q);
    retire     = (state_q == StWrite) && !rst;
    gpr_wen    = (state_q == StWrite) && pending;
    gpr_waddr  = rst ? 5'd0 : rd_q;
    gpr_wdata  = rst ? 32'd0 : data_q;
`ifdef NPC_WBU_FWD_EN
    fwd_valid  = gpr_wen;
    fwd_rd     = gpr_wen ? rd_q : 5'd0;
    fwd_data   = gpr_wen ? data_q : 32'd0;
    // A match in WRITE is covered by the forward path, so decode need not stall.
    hazard     = pending && src_match && (state_q != StWrite);
`else
    hazard     = pending && src_match;
`endif
  end

endmodule

// File: tb/tb_npc_wbu.sv
// Directed self-checking bench for npc_wbu; covers reset, ALU writes, load extension,
// x0 handling, hazard detection (with or without NPC_WBU_FWD_EN) and reset mid-load.
module tb_npc_wbu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_ld_func;
  logic [1:0]  in_ld_addr_lo;
  logic [31:0] in_result;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        retire;
`ifdef NPC_WBU_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        hazard;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] MemWord = 32'h8081F27F;

  npc_wbu dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_rd_wen     (in_rd_wen),
    .in_is_load    (in_is_load),
    .in_ld_func    (in_ld_func),
    .in_ld_addr_lo (in_ld_addr_lo),
    .in_result     (in_result),
    .mem_rvalid    (mem_rvalid),
    .mem_rready    (mem_rready),
    .mem_rdata     (mem_rdata),
    .gpr_wen       (gpr_wen),
    .gpr_waddr     (gpr_waddr),
    .gpr_wdata     (gpr_wdata),
    .retire        (retire),
`ifdef NPC_WBU_FWD_EN
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
`endif
    .chk_rs1       (chk_rs1),
    .chk_rs2       (chk_rs2),
    .hazard        (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [2:0] func, input logic [1:0] lo, input logic [31:0] res);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_rd_wen     = wen;
    in_is_load    = ld;
    in_ld_func    = func;
    in_ld_addr_lo = lo;
    in_result     = res;
    step();
    in_valid = 1'b0;
  endtask

  // Load of MemWord with read data returned after three WAIT_MEM cycles; checks WRITE.
  task automatic do_load(input string tag, input logic [2:0] func, input logic [1:0] lo,
                         input logic [31:0] exp);
    issue(5'd12, 1'b1, 1'b1, func, lo, 32'h1111_1111);
    chk({tag, "_rready"}, {31'd0, mem_rready}, 32'd1);
    step();
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = MemWord;
    step();
    mem_rvalid = 1'b0;
    chk({tag, "_wen"}, {31'd0, gpr_wen}, 32'd1);
    chk({tag, "_wdata"}, gpr_wdata, exp);
    step();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_rd = 5'd0;
    in_rd_wen = 1'b0;
    in_is_load = 1'b0;
    in_ld_func = 3'd0;
    in_ld_addr_lo = 2'd0;
    in_result = 32'd0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'd0;
    chk_rs1 = 5'd0;
    chk_rs2 = 5'd0;

    // Reset hold
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_rready", {31'd0, mem_rready}, 32'd0);
    chk("rst_gpr_wen", {31'd0, gpr_wen}, 32'd0);
    chk("rst_waddr", {27'd0, gpr_waddr}, 32'd0);
    chk("rst_wdata", gpr_wdata, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    rst = 1'b0;
    step();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_hazard", {31'd0, hazard}, 32'd0);

    // ALU write
    issue(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEADBEEF);
    chk("alu_wen", {31'd0, gpr_wen}, 32'd1);
    chk("alu_waddr", {27'd0, gpr_waddr}, 32'd5);
    chk("alu_wdata", gpr_wdata, 32'hDEADBEEF);
    chk("alu_retire", {31'd0, retire}, 32'd1);
    chk("alu_not_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("alu_ready_again", {31'd0, in_ready}, 32'd1);
    chk("alu_wen_off", {31'd0, gpr_wen}, 32'd0);
    chk("alu_retire_off", {31'd0, retire}, 32'd0);

    // Load extension
    do_load("lb0", 3'b000, 2'd0, 32'h0000007F);
    do_load("lb3", 3'b000, 2'd3, 32'hFFFFFF80);
    do_load("lbu3", 3'b100, 2'd3, 32'h00000080);
    do_load("lb1", 3'b000, 2'd1, 32'hFFFFFFF2);
    do_load("lh2", 3'b001, 2'd2, 32'hFFFF8081);
    do_load("lh0", 3'b001, 2'd0, 32'hFFFFF27F);
    do_load("lhu3", 3'b101, 2'd3, 32'h00008081);
    do_load("lw", 3'b010, 2'd0, 32'h8081F27F);
    do_load("f011", 3'b011, 2'd1, 32'h8081F27F);

    // rvalid outside WAIT_MEM is ignored
    mem_rvalid = 1'b1;
    step();
    chk("stray_rvalid_ready", {31'd0, in_ready}, 32'd1);
    chk("stray_rvalid_retire", {31'd0, retire}, 32'd0);
    mem_rvalid = 1'b0;

    // x0 load and no-write ALU op
    chk_rs1 = 5'd0;
    issue(5'd0, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0);
    chk("x0_wait_hazard", {31'd0, hazard}, 32'd0);
    chk("x0_wait_retire", {31'd0, retire}, 32'd0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    step();
    mem_rvalid = 1'b0;
    chk("x0_retire", {31'd0, retire}, 32'd1);
    chk("x0_wen", {31'd0, gpr_wen}, 32'd0);
    chk("x0_hazard", {31'd0, hazard}, 32'd0);
    step();
    chk_rs1 = 5'd3;
    issue(5'd3, 1'b0, 1'b0, 3'd0, 2'd0, 32'hCAFEF00D);
    chk("nowen_retire", {31'd0, retire}, 32'd1);
    chk("nowen_wen", {31'd0, gpr_wen}, 32'd0);
    chk("nowen_hazard", {31'd0, hazard}, 32'd0);
    step();
    chk_rs1 = 5'd0;

    // Hazard on a pending load to x7
    chk_rs2 = 5'd7;
    issue(5'd7, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0);
    chk("hz_wait0", {31'd0, hazard}, 32'd1);
    chk_rs2 = 5'd8;
    #1;
    chk("hz_nomatch", {31'd0, hazard}, 32'd0);
    chk_rs1 = 5'd7;
    #1;
    chk("hz_rs1_comb", {31'd0, hazard}, 32'd1);
    chk_rs1 = 5'd0;
    chk_rs2 = 5'd7;
    step();
    chk("hz_wait1", {31'd0, hazard}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A55A5A;
    step();
    mem_rvalid = 1'b0;
    chk("hz_write_wdata", gpr_wdata, 32'hA5A55A5A);
`ifdef NPC_WBU_FWD_EN
    chk("hz_write_fwd_hazard", {31'd0, hazard}, 32'd0);
    chk("hz_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("hz_fwd_rd", {27'd0, fwd_rd}, 32'd7);
    chk("hz_fwd_data", fwd_data, 32'hA5A55A5A);
`else
    chk("hz_write_hazard", {31'd0, hazard}, 32'd1);
`endif
    step();
    chk("hz_after", {31'd0, hazard}, 32'd0);
    chk_rs2 = 5'd0;

    // Reset mid-load
    issue(5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0);
    chk("rml_waiting", {31'd0, mem_rready}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rml_rst_rready", {31'd0, mem_rready}, 32'd0);
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    #1;
    chk("rml_idle", {31'd0, in_ready}, 32'd1);
    chk("rml_rready", {31'd0, mem_rready}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    chk("rml_wen", {31'd0, gpr_wen}, 32'd0);
    chk("rml_retire", {31'd0, retire}, 32'd0);
    chk("rml_still_idle", {31'd0, in_ready}, 32'd1);
    step();
    chk("rml_retire2", {31'd0, retire}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
